l2_dcache_resp: RTL and testbench

- Responder end of the L1-dcache-to-L2 request interface. It accepts dcache requests (drq, l2_addr, l2_cache_rw, victim sub-block) and answers with l2_busy, l2_rdy, l2_complete and a 128-bit sub-block.
- It controls a 2-way, 512-set, 64-byte-line L2 tag/data/dirty array.
- It refills from and writes back to main memory over a simple request/ready port.

---
 rtl/l2_dcache_resp.sv | 203 ++++++++++++++++++++
 tb/tb_l2_dcache_resp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_dcache_resp.sv
// l2_dcache_resp
// Responder end of the L1-dcache-to-L2 request interface. Serves L1 line
// fills (reads) and L1 dirty-victim writebacks (writes) from a 2-way,
// 512-set, 64-byte-line L2 array, refilling from and writing back to main
// memory over a request/ready port.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   drq, l2_addr,            dcache request: address, rw (1 = write),
//   l2_cache_rw, l1_wd       victim sub-block for writes
//   complete                 L1 has consumed l2_rd
//   l2_busy, l2_rdy,         responder status, read data valid,
//   l2_complete, l2_rd       write-done pulse, returned sub-block
//   tag*_rd, data*_rd,       per-way array read data (valid the cycle
//   dirty*, lru              after set_index changes), replacement hint
//   set_index, tag_wd,       array index and write data; way*_we writes
//   data_wd, dirty_wd,       tag+data+dirty of that way at the clock edge
//   way0_we, way1_we
//   mem_rq, mem_rw,          memory request (rw 1 = line writeback),
//   mem_addr, mem_wd,        line address and writeback data,
//   mem_rd, mem_rdy          fetched line and one-cycle done pulse
module l2_dcache_resp #(
  parameter int TAG_W  = 17,
  parameter int LINE_W = 512,
  parameter int SUB_W  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drq,
  input  logic [31:0]       l2_addr,
  input  logic              l2_cache_rw,
  input  logic [SUB_W-1:0]  l1_wd,
  input  logic              complete,
  output logic              l2_busy,
  output logic              l2_rdy,
  output logic              l2_complete,
  output logic [SUB_W-1:0]  l2_rd,
  input  logic [TAG_W:0]    tag0_rd,
  input  logic [TAG_W:0]    tag1_rd,
  input  logic [LINE_W-1:0] data0_rd,
  input  logic [LINE_W-1:0] data1_rd,
  input  logic              dirty0,
  input  logic              dirty1,
  input  logic              lru,
  output logic [8:0]        set_index,
  output logic [TAG_W:0]    tag_wd,
  output logic [LINE_W-1:0] data_wd,
  output logic              dirty_wd,
  output logic              way0_we,
  output logic              way1_we,
  output logic              mem_rq,
  output logic              mem_rw,
  output logic [25:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wd,
  input  logic [LINE_W-1:0] mem_rd,
  input  logic              mem_rdy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ACCESS  = 3'd1;
  localparam logic [2:0] RD_HIT  = 3'd2;
  localparam logic [2:0] WR_HIT  = 3'd3;
  localparam logic [2:0] MEM_WB  = 3'd4;
  localparam logic [2:0] MEM_GAP = 3'd5;  // mem_rq low between writeback and refill
  localparam logic [2:0] MEM_RD  = 3'd6;
  localparam logic [2:0] FILL    = 3'd7;

  logic [2:0]        state;
  logic [TAG_W-1:0]  req_tag;
  logic [1:0]        req_sub;
  logic              req_rw;
  logic [SUB_W-1:0]  req_wd;
  logic              hit_way;
  logic              victim_way;
  logic [LINE_W-1:0] fill_line;

  // Byte offset [3:0] never matters: L1 transfers whole sub-blocks.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, l2_addr[3:0]};

  // Tag compare and victim choice, meaningful only in ACCESS.
  logic hit0, hit1, hit, hit_sel;
  logic victim_sel, victim_valid, victim_dirty;
  logic [LINE_W-1:0] hit_line;

  assign hit0    = tag0_rd[TAG_W] && (tag0_rd[TAG_W-1:0] == req_tag);
  assign hit1    = tag1_rd[TAG_W] && (tag1_rd[TAG_W-1:0] == req_tag);
  assign hit     = hit0 || hit1;
  assign hit_sel = !hit0;  // way0 wins when both hit

  assign victim_sel   = !tag0_rd[TAG_W] ? 1'b0 : (!tag1_rd[TAG_W] ? 1'b1 : lru);
  assign victim_valid = victim_sel ? tag1_rd[TAG_W] : tag0_rd[TAG_W];
  assign victim_dirty = victim_sel ? dirty1 : dirty0;

  assign hit_line = hit_sel ? data1_rd : data0_rd;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the wide datapath registers are reset too, because l2_rd must read
  // as zero out of reset and the cost of an async clear is negligible here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_tag    <= '0;
      req_sub    <= '0;
      req_rw     <= 1'b0;
      req_wd     <= '0;
      hit_way    <= 1'b0;
      victim_way <= 1'b0;
      fill_line  <= '0;
      set_index  <= '0;
      l2_rd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (drq) begin
            req_tag   <= l2_addr[31:15];
            req_sub   <= l2_addr[5:4];
            req_rw    <= l2_cache_rw;
            req_wd    <= l1_wd;
            set_index <= l2_addr[14:6];
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (hit) begin
            hit_way <= hit_sel;
            if (!req_rw) begin
              l2_rd <= hit_line[req_sub*SUB_W +: SUB_W];
              state <= RD_HIT;
            end else begin
              state <= WR_HIT;
            end
          end else begin
            victim_way <= victim_sel;
            state      <= (victim_valid && victim_dirty) ? MEM_WB : MEM_RD;
          end
        end
        RD_HIT:  if (complete) state <= IDLE;
        WR_HIT:  state <= IDLE;
        MEM_WB:  if (mem_rdy) state <= MEM_GAP;
        MEM_GAP: state <= MEM_RD;
        MEM_RD: begin
          if (mem_rdy) begin
            fill_line <= mem_rd;
            state     <= FILL;
          end
        end
        FILL:    state <= ACCESS;  // re-lookup now hits the filled way
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state, so reset clears them asynchronously.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    logic [LINE_W-1:0] merged;
    l2_busy     = (state != IDLE);
    l2_rdy      = (state == RD_HIT);
    l2_complete = (state == WR_HIT);
    tag_wd      = '0;
    data_wd     = '0;
    dirty_wd    = 1'b0;
    way0_we     = 1'b0;
    way1_we     = 1'b0;
    mem_rq      = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_wd      = '0;
    merged      = hit_way ? data1_rd : data0_rd;
    merged[req_sub*SUB_W +: SUB_W] = req_wd;

    case (state)
      WR_HIT: begin
        tag_wd   = {1'b1, req_tag};
        data_wd  = merged;
        dirty_wd = 1'b1;
        way0_we  = !hit_way;
        way1_we  = hit_way;
      end
      MEM_WB: begin
        mem_rq   = 1'b1;
        mem_rw   = 1'b1;
        mem_addr = victim_way ? {tag1_rd[TAG_W-1:0], set_index}
                              : {tag0_rd[TAG_W-1:0], set_index};
        mem_wd   = victim_way ? data1_rd : data0_rd;
      end
      MEM_RD: begin
        mem_rq   = 1'b1;
        mem_addr = {req_tag, set_index};
      end
      FILL: begin
        tag_wd   = {1'b1, req_tag};
        data_wd  = fill_line;
        way0_we  = !victim_way;
        way1_we  = victim_way;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_dcache_resp.sv
// Directed bench for l2_dcache_resp with a behavioural 2-way tag/data/dirty
// array (combinational read at set_index, write at the clock edge) and a
// hand-driven memory port. Inputs change and outputs are sampled on negedge.
module tb_l2_dcache_resp;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         drq = 1'b0;
  logic [31:0]  l2_addr = '0;
  logic         l2_cache_rw = 1'b0;
  logic [127:0] l1_wd = '0;
  logic         complete = 1'b0;
  logic         l2_busy, l2_rdy, l2_complete;
  logic [127:0] l2_rd;
  logic [17:0]  tag0_rd, tag1_rd;
  logic [511:0] data0_rd, data1_rd;
  logic         dirty0, dirty1;
  logic         lru = 1'b0;
  logic [8:0]   set_index;
  logic [17:0]  tag_wd;
  logic [511:0] data_wd;
  logic         dirty_wd, way0_we, way1_we;
  logic         mem_rq, mem_rw;
  logic [25:0]  mem_addr;
  logic [511:0] mem_wd;
  logic [511:0] mem_rd = '0;
  logic         mem_rdy = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l2_dcache_resp dut (
    .clk(clk), .rst(rst), .drq(drq), .l2_addr(l2_addr),
    .l2_cache_rw(l2_cache_rw), .l1_wd(l1_wd), .complete(complete),
    .l2_busy(l2_busy), .l2_rdy(l2_rdy), .l2_complete(l2_complete),
    .l2_rd(l2_rd), .tag0_rd(tag0_rd), .tag1_rd(tag1_rd),
    .data0_rd(data0_rd), .data1_rd(data1_rd), .dirty0(dirty0),
    .dirty1(dirty1), .lru(lru), .set_index(set_index), .tag_wd(tag_wd),
    .data_wd(data_wd), .dirty_wd(dirty_wd), .way0_we(way0_we),
    .way1_we(way1_we), .mem_rq(mem_rq), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_rdy(mem_rdy)
  );

  // Array model; the preload port and clear share the single writer process.
  logic [17:0]  tag_a   [2][512];
  logic [511:0] data_a  [2][512];
  logic         dirty_a [2][512];
  logic         clr = 1'b0;
  logic         pl_we = 1'b0, pl_way = 1'b0, pl_dirty = 1'b0;
  logic [8:0]   pl_set = '0;
  logic [17:0]  pl_tag = '0;
  logic [511:0] pl_data = '0;

  assign tag0_rd  = tag_a[0][set_index];
  assign tag1_rd  = tag_a[1][set_index];
  assign data0_rd = data_a[0][set_index];
  assign data1_rd = data_a[1][set_index];
  assign dirty0   = dirty_a[0][set_index];
  assign dirty1   = dirty_a[1][set_index];

  always @(posedge clk) begin
    if (clr) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 512; s++) begin
          tag_a[w][s] <= '0; data_a[w][s] <= '0; dirty_a[w][s] <= 1'b0;
        end
    end else if (pl_we) begin
      tag_a[pl_way][pl_set] <= pl_tag;
      data_a[pl_way][pl_set] <= pl_data;
      dirty_a[pl_way][pl_set] <= pl_dirty;
    end else begin
      if (way0_we) begin
        tag_a[0][set_index] <= tag_wd; data_a[0][set_index] <= data_wd;
        dirty_a[0][set_index] <= dirty_wd;
      end
      if (way1_we) begin
        tag_a[1][set_index] <= tag_wd; data_a[1][set_index] <= data_wd;
        dirty_a[1][set_index] <= dirty_wd;
      end
    end
  end

  function automatic logic [31:0] mk_addr(input logic [16:0] tag, input logic [8:0] set,
                                          input logic [1:0] sub);
    return {tag, set, sub, 4'h0};
  endfunction

  task automatic preload(input logic way, input logic [8:0] set, input logic [16:0] tag,
                         input logic [511:0] line, input logic dirty);
    @(negedge clk);
    pl_we = 1'b1; pl_way = way; pl_set = set; pl_tag = {1'b1, tag};
    pl_data = line; pl_dirty = dirty;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Presents a request for one cycle; returns at the negedge of cycle 1.
  task automatic issue(input logic [31:0] addr, input logic rw, input logic [127:0] wd);
    @(negedge clk);
    drq = 1'b1; l2_addr = addr; l2_cache_rw = rw; l1_wd = wd;
    @(negedge clk);
    drq = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", l2_busy); end
    checks++; if (l2_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", l2_rdy); end
    checks++; if (l2_rd !== '0) begin errors++; $display("FAIL reset_l2_rd: got %h want 0", l2_rd); end
    checks++; if (mem_rq !== 1'b0) begin errors++; $display("FAIL reset_mem_rq: got %b want 0", mem_rq); end
    checks++; if (mem_wd !== '0) begin errors++; $display("FAIL reset_mem_wd: got %h want 0", mem_wd); end
    checks++; if (set_index !== 9'd0) begin errors++; $display("FAIL reset_set_index: got %h want 0", set_index); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_hit;
    logic [511:0] line;
    line = {{16{8'h03}}, {16{8'hA5}}, {16{8'h01}}, {16{8'h00}}};
    preload(1'b1, 9'd64, 17'h00012, line, 1'b0);
    issue(mk_addr(17'h00012, 9'd64, 2'd2), 1'b0, '0);
    checks++; if (l2_busy !== 1'b1 || l2_rdy !== 1'b0) begin errors++; $display("FAIL rdhit_cycle1: got busy=%b rdy=%b want busy=1 rdy=0", l2_busy, l2_rdy); end
    @(negedge clk);
    checks++; if (l2_rdy !== 1'b1) begin errors++; $display("FAIL rdhit_rdy: got %b want 1", l2_rdy); end
    checks++; if (l2_rd !== {16{8'hA5}}) begin errors++; $display("FAIL rdhit_data: got %h want a5..a5", l2_rd); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (l2_rdy !== 1'b1 || l2_rd !== {16{8'hA5}}) begin errors++; $display("FAIL rdhit_hold%0d: got rdy=%b rd=%h want rdy=1 rd=a5..a5", i, l2_rdy, l2_rd); end
    end
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0;
    checks++; if (l2_rdy !== 1'b0 || l2_busy !== 1'b0) begin errors++; $display("FAIL rdhit_release: got rdy=%b busy=%b want 0 0", l2_rdy, l2_busy); end
  endtask

  task automatic test_write_hit;
    logic [511:0] line, exp;
    logic [127:0] wd;
    line = {{16{8'h13}}, {16{8'h12}}, {16{8'h11}}, {16{8'h10}}};
    wd   = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    exp  = {{16{8'h13}}, {16{8'h12}}, wd, {16{8'h10}}};
    preload(1'b0, 9'd5, 17'h00033, line, 1'b0);
    issue(mk_addr(17'h00033, 9'd5, 2'd1), 1'b1, wd);
    @(negedge clk);
    checks++; if (way0_we !== 1'b1 || way1_we !== 1'b0) begin errors++; $display("FAIL wrhit_we: got we0=%b we1=%b want 1 0", way0_we, way1_we); end
    checks++; if (data_wd !== exp) begin errors++; $display("FAIL wrhit_data: got %h want %h", data_wd, exp); end
    checks++; if (dirty_wd !== 1'b1 || tag_wd !== {1'b1, 17'h00033}) begin errors++; $display("FAIL wrhit_tag_dirty: got tag=%h dirty=%b want %h 1", tag_wd, dirty_wd, {1'b1, 17'h00033}); end
    checks++; if (l2_complete !== 1'b1) begin errors++; $display("FAIL wrhit_complete: got %b want 1", l2_complete); end
    @(negedge clk);
    checks++; if (l2_complete !== 1'b0 || way0_we !== 1'b0 || l2_busy !== 1'b0) begin errors++; $display("FAIL wrhit_after: got cmp=%b we0=%b busy=%b want 0 0 0", l2_complete, way0_we, l2_busy); end
    checks++; if (data_a[0][5] !== exp || dirty_a[0][5] !== 1'b1) begin errors++; $display("FAIL wrhit_array: got %h dirty=%b want %h 1", data_a[0][5], dirty_a[0][5], exp); end
  endtask

  task automatic test_clean_miss;
    logic [511:0] ml;
    logic [31:0] a;
    ml = {{16{8'h73}}, {16{8'h72}}, {16{8'h71}}, {16{8'h70}}};
    a  = mk_addr(17'h00044, 9'd7, 2'd3);
    issue(a, 1'b0, '0);
    @(negedge clk);
    checks++; if (mem_rq !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== a[31:6]) begin errors++; $display("FAIL cmiss_req: got rq=%b rw=%b addr=%h want 1 0 %h", mem_rq, mem_rw, mem_addr, a[31:6]); end
    repeat (9) @(negedge clk);
    checks++; if (mem_rq !== 1'b1 || way0_we !== 1'b0) begin errors++; $display("FAIL cmiss_wait: got rq=%b we0=%b want 1 0", mem_rq, way0_we); end
    mem_rdy = 1'b1; mem_rd = ml;
    @(negedge clk);
    mem_rdy = 1'b0; mem_rd = '0;
    checks++; if (way0_we !== 1'b1 || way1_we !== 1'b0 || dirty_wd !== 1'b0 || data_wd !== ml) begin errors++; $display("FAIL cmiss_fill: got we0=%b we1=%b dirty=%b data=%h", way0_we, way1_we, dirty_wd, data_wd); end
    checks++; if (tag_wd !== {1'b1, 17'h00044} || mem_rq !== 1'b0) begin errors++; $display("FAIL cmiss_fill_tag: got tag=%h rq=%b want %h 0", tag_wd, mem_rq, {1'b1, 17'h00044}); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (l2_rdy !== 1'b1 || l2_rd !== {16{8'h73}}) begin errors++; $display("FAIL cmiss_rd: got rdy=%b rd=%h want 1 73..73", l2_rdy, l2_rd); end
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0;
  endtask

  task automatic test_dirty_miss;
    logic [511:0] v, ml;
    logic [31:0] a;
    v  = {{16{8'hD3}}, {16{8'hD2}}, {16{8'hD1}}, {16{8'hD0}}};
    ml = {{16{8'h93}}, {16{8'h92}}, {16{8'h91}}, {16{8'h90}}};
    a  = mk_addr(17'h00055, 9'd9, 2'd0);
    preload(1'b0, 9'd9, 17'h00010, '0, 1'b0);
    preload(1'b1, 9'd9, 17'h00011, v, 1'b1);
    lru = 1'b1;
    issue(a, 1'b0, '0);
    @(negedge clk);
    checks++; if (mem_rq !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== {17'h00011, 9'd9}) begin errors++; $display("FAIL dmiss_wb_req: got rq=%b rw=%b addr=%h want 1 1 %h", mem_rq, mem_rw, mem_addr, {17'h00011, 9'd9}); end
    checks++; if (mem_wd !== v) begin errors++; $display("FAIL dmiss_wb_data: got %h want %h", mem_wd, v); end
    repeat (2) @(negedge clk);
    mem_rdy = 1'b1;
    @(negedge clk);
    mem_rdy = 1'b0;
    checks++; if (mem_rq !== 1'b0) begin errors++; $display("FAIL dmiss_gap: got %b want 0", mem_rq); end
    @(negedge clk);
    checks++; if (mem_rq !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== a[31:6]) begin errors++; $display("FAIL dmiss_rd_req: got rq=%b rw=%b addr=%h want 1 0 %h", mem_rq, mem_rw, mem_addr, a[31:6]); end
    mem_rdy = 1'b1; mem_rd = ml;
    @(negedge clk);
    mem_rdy = 1'b0; mem_rd = '0;
    checks++; if (way1_we !== 1'b1 || way0_we !== 1'b0 || dirty_wd !== 1'b0) begin errors++; $display("FAIL dmiss_fill: got we0=%b we1=%b dirty=%b want 0 1 0", way0_we, way1_we, dirty_wd); end
    repeat (2) @(negedge clk);
    checks++; if (l2_rdy !== 1'b1 || l2_rd !== {16{8'h90}}) begin errors++; $display("FAIL dmiss_rd: got rdy=%b rd=%h want 1 90..90", l2_rdy, l2_rd); end
    checks++; if (tag_a[0][9] !== {1'b1, 17'h00010} || tag_a[1][9] !== {1'b1, 17'h00055}) begin errors++; $display("FAIL dmiss_tags: got %h %h", tag_a[0][9], tag_a[1][9]); end
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0; lru = 1'b0;
  endtask

  task automatic test_write_miss;
    logic [511:0] ml, exp;
    logic [127:0] wd;
    ml  = {{16{8'hB3}}, {16{8'hB2}}, {16{8'hB1}}, {16{8'hB0}}};
    wd  = {4{32'hCAFE_F00D}};
    exp = {{16{8'hB3}}, wd, {16{8'hB1}}, {16{8'hB0}}};
    issue(mk_addr(17'h00066, 9'd11, 2'd2), 1'b1, wd);
    @(negedge clk);
    checks++; if (mem_rq !== 1'b1 || mem_rw !== 1'b0) begin errors++; $display("FAIL wmiss_req: got rq=%b rw=%b want 1 0", mem_rq, mem_rw); end
    mem_rdy = 1'b1; mem_rd = ml;
    @(negedge clk);
    mem_rdy = 1'b0; mem_rd = '0;
    checks++; if (way0_we !== 1'b1 || data_wd !== ml || l2_complete !== 1'b0) begin errors++; $display("FAIL wmiss_fill: got we0=%b cmp=%b data=%h", way0_we, l2_complete, data_wd); end
    repeat (2) @(negedge clk);
    checks++; if (l2_complete !== 1'b1 || way0_we !== 1'b1 || dirty_wd !== 1'b1 || data_wd !== exp) begin errors++; $display("FAIL wmiss_wrhit: got cmp=%b we0=%b dirty=%b data=%h", l2_complete, way0_we, dirty_wd, data_wd); end
    @(negedge clk);
    checks++; if (data_a[0][11] !== exp || dirty_a[0][11] !== 1'b1 || l2_busy !== 1'b0) begin errors++; $display("FAIL wmiss_final: got %h dirty=%b busy=%b", data_a[0][11], dirty_a[0][11], l2_busy); end
  endtask

  task automatic test_reset_midflight;
    issue(mk_addr(17'h00077, 9'd13, 2'd0), 1'b0, '0);
    @(negedge clk);
    checks++; if (mem_rq !== 1'b1) begin errors++; $display("FAIL rstmid_rq: got %b want 1", mem_rq); end
    drq = 1'b1; l2_addr = mk_addr(17'h00078, 9'd14, 2'd1);  // ignored while busy
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_rq !== 1'b0 || l2_busy !== 1'b0) begin errors++; $display("FAIL rstmid_async: got rq=%b busy=%b want 0 0", mem_rq, l2_busy); end
    drq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_rdy = 1'b1;  // stray pulse in IDLE must be ignored
    @(negedge clk);
    mem_rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (l2_busy !== 1'b0 || mem_rq !== 1'b0 || set_index !== 9'd0) begin errors++; $display("FAIL rstmid_idle: got busy=%b rq=%b set=%h want 0 0 0", l2_busy, mem_rq, set_index); end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_write_miss();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
